// File: rtl/minisys_int_pkg.sv
// minisys_int_pkg
//   Shared constants for the MiniSys interrupt controller: line count,
//   line assignments from the interrupt source mapper, and the FSM state
//   encodings used by interrupt_controller.
//   No ports (package).
package minisys_int_pkg;

  localparam int NUM_IRQ = 6;
  localparam int ID_W    = $clog2(NUM_IRQ);

  // Line assignments as presented by the interrupt source mapper.
  localparam int IRQ_KEYBOARD = 0;
  localparam int IRQ_S1       = 1;
  localparam int IRQ_S2       = 2;
  localparam int IRQ_S3       = 3;
  localparam int IRQ_S4       = 4;
  localparam int IRQ_S5       = 5;

  // FSM state encodings, kept as plain constants for legacy tools.
  typedef logic [1:0] int_state_t;
  localparam int_state_t ST_IDLE    = 2'b00;
  localparam int_state_t ST_REQ     = 2'b01;
  localparam int_state_t ST_SERVICE = 2'b10;

endpackage

// File: rtl/int_sync_edge.sv
// int_sync_edge
//   Synchronises one asynchronous interrupt line into the clock domain and
//   produces a single-cycle pulse on each rising edge of the synchronised
//   level. History resets to 0, so a line held high across reset release
//   is reported as one rising edge.
// Ports
//   clock   in  1  system clock
//   resetn  in  1  asynchronous active-low reset
//   din     in  1  raw interrupt line (asynchronous)
//   rise    out 1  one-cycle pulse, high for the cycle after the
//                  synchronised level goes 0 -> 1
module int_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   hist_d;

  // Next-state for the synchroniser shift chain and the edge history.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and history flops.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  // Both operands are flops, so the pulse is glitch-free for the consumer.
  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Turns the raw interrupt vector from the source mapper into one CPU
//   interrupt request for CP0. Each line is synchronised and its rising
//   edges latched as pending; pending lines are masked by Status.IM, gated
//   by Status.IE and arbitrated by fixed priority (bit 0 highest). A
//   request/acknowledge/return handshake runs with the CPU; no nesting.
// Ports
//   clock        in   1        system clock
//   resetn       in   1        asynchronous active-low reset
//   irq_in       in   NUM_IRQ  raw level interrupt lines (asynchronous)
//   irq_mask     in   NUM_IRQ  CP0 Status.IM, 1 = line enabled
//   global_ie    in   1        CP0 Status.IE, 0 blocks new requests
//   int_ack      in   1        pulse: CPU has taken the exception for int_id
//   eret         in   1        pulse: handler has returned
//   int_req      out  1        registered request to CPU
//   int_id       out  ID_W     registered index being requested/serviced
//   int_pending  out  NUM_IRQ  registered pending vector, unmasked
//   in_service   out  1        registered, high from ack until eret
module interrupt_controller
  import minisys_int_pkg::*;
#(
  parameter int NUM_IRQ     = minisys_int_pkg::NUM_IRQ,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_IRQ-1:0]         irq_in,
  input  logic [NUM_IRQ-1:0]         irq_mask,
  input  logic                       global_ie,
  input  logic                       int_ack,
  input  logic                       eret,
  output logic                       int_req,
  output logic [$clog2(NUM_IRQ)-1:0] int_id,
  output logic [NUM_IRQ-1:0]         int_pending,
  output logic                       in_service
);

  localparam int IW = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0] rise_s;
  logic [NUM_IRQ-1:0] eligible_s;
  logic [NUM_IRQ-1:0] clr_s;
  logic [IW-1:0]      winner_s;
  logic               any_s;

  int_state_t         state_q;
  int_state_t         state_d;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;
  logic               int_req_q;
  logic               int_req_d;
  logic [IW-1:0]      int_id_q;
  logic [IW-1:0]      int_id_d;
  logic               in_service_q;
  logic               in_service_d;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    int_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clock  (clock),
      .resetn (resetn),
      .din    (irq_in[g]),
      .rise   (rise_s[g])
    );
  end

  // Fixed-priority encoder: scanning downward leaves the lowest set index.
  always_comb begin
    eligible_s = pending_q & irq_mask;
    any_s      = |eligible_s;
    winner_s   = {IW{1'b0}};
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      winner_s = eligible_s[i] ? IW'(i) : winner_s;
    end
  end

  // Request/acknowledge/return FSM and pending-clear generation.
  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    int_id_d     = int_id_q;
    in_service_d = in_service_q;
    clr_s        = {NUM_IRQ{1'b0}};
    case (state_q)
      ST_IDLE: begin
        in_service_d = 1'b0;
        if (global_ie && any_s) begin
          state_d   = ST_REQ;
          int_req_d = 1'b1;
          int_id_d  = winner_s;
        end else begin
          state_d   = ST_IDLE;
          int_req_d = 1'b0;
        end
      end
      ST_REQ: begin
        // An ack means the CPU already committed to int_id, so it takes
        // precedence over a simultaneous loss of eligibility.
        if (int_ack) begin
          state_d      = ST_SERVICE;
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
          clr_s        = {{(NUM_IRQ-1){1'b0}}, 1'b1} << int_id_q;
        end else if (!global_ie || !any_s) begin
          state_d   = ST_IDLE;
          int_req_d = 1'b0;
        end else begin
          state_d   = ST_REQ;
          int_req_d = 1'b1;
          int_id_d  = winner_s;
        end
      end
      ST_SERVICE: begin
        int_req_d = 1'b0;
        if (eret) begin
          state_d      = ST_IDLE;
          in_service_d = 1'b0;
        end else begin
          state_d      = ST_SERVICE;
          in_service_d = 1'b1;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        int_req_d    = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
    // A fresh edge in the same cycle as the ack-clear must not be lost.
    pending_d = (pending_q & ~clr_s) | rise_s;
  end

  // State, pending and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      pending_q    <= {NUM_IRQ{1'b0}};
      int_req_q    <= 1'b0;
      int_id_q     <= {IW{1'b0}};
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      int_req_q    <= int_req_d;
      int_id_q     <= int_id_d;
      in_service_q <= in_service_d;
    end
  end

  assign int_req     = int_req_q;
  assign int_id      = int_id_q;
  assign int_pending = pending_q;
  assign in_service  = in_service_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller
//   Directed self-checking bench for interrupt_controller. Expected output
//   snapshots {int_req, int_id, int_pending, in_service} are queued when
//   stimulus is driven and popped/compared once the DUT has clocked.
module tb_interrupt_controller;

  logic       clock = 1'b0;
  logic       resetn;
  logic [5:0] irq_in;
  logic [5:0] irq_mask;
  logic       global_ie;
  logic       int_ack;
  logic       eret;
  logic       int_req;
  logic [2:0] int_id;
  logic [5:0] int_pending;
  logic       in_service;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  interrupt_controller #(
    .NUM_IRQ(6),
    .SYNC_STAGES(2)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .irq_in      (irq_in),
    .irq_mask    (irq_mask),
    .global_ie   (global_ie),
    .int_ack     (int_ack),
    .eret        (eret),
    .int_req     (int_req),
    .int_id      (int_id),
    .int_pending (int_pending),
    .in_service  (in_service)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input string tag, input logic r, input logic [2:0] id,
                      input logic [5:0] p, input logic s);
    exp_t e;
    e.tag = tag;
    e.exp = {r, id, p, s};
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [10:0] obs;
    obs = {int_req, int_id, int_pending, in_service};
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        tests_failed++;
        $error("FAIL %s observed req/id/pend/svc=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    logic [5:0] pend;

    // ---- 1: line high across reset release, all lines pending ----
    resetn    = 1'b0;
    irq_in    = 6'h3F;
    irq_mask  = 6'h3F;
    global_ie = 1'b1;
    int_ack   = 1'b0;
    eret      = 1'b0;
    repeat (3) tick();
    push("reset_state", 1'b0, 3'd0, 6'h00, 1'b0); check();
    resetn = 1'b1;
    push("t1_edge1", 1'b0, 3'd0, 6'h00, 1'b0); tick(); check();
    push("t1_edge2", 1'b0, 3'd0, 6'h00, 1'b0); tick(); check();
    push("t1_edge3_pend", 1'b0, 3'd0, 6'h3F, 1'b0); tick(); check();
    push("t1_edge4_req", 1'b1, 3'd0, 6'h3F, 1'b0); tick(); check();
    irq_in = 6'h00;
    pend   = 6'h3F;
    // Drain in priority order, one ack/eret round per line.
    for (int i = 0; i < 6; i++) begin
      pend    = pend & ~(6'b000001 << i);
      int_ack = 1'b1;
      push("t1_drain_ack", 1'b0, 3'(i), pend, 1'b1);
      tick(); int_ack = 1'b0; check();
      eret = 1'b1;
      push("t1_drain_eret", 1'b0, 3'(i), pend, 1'b0);
      tick(); eret = 1'b0; check();
      if (i < 5) push("t1_drain_rereq", 1'b1, 3'(i + 1), pend, 1'b0);
      else       push("t1_drain_idle", 1'b0, 3'd5, 6'h00, 1'b0);
      tick(); check();
    end

    // ---- 2: single pulse on line 3, full handshake ----
    irq_in = 6'h08;
    tick(); tick();
    irq_in = 6'h00;
    push("t2_pend", 1'b0, 3'd5, 6'h08, 1'b0); tick(); check();
    push("t2_req", 1'b1, 3'd3, 6'h08, 1'b0); tick(); check();
    int_ack = 1'b1;
    push("t2_ack", 1'b0, 3'd3, 6'h00, 1'b1); tick(); int_ack = 1'b0; check();
    eret = 1'b1;
    push("t2_eret", 1'b0, 3'd3, 6'h00, 1'b0); tick(); eret = 1'b0; check();
    push("t2_stay_idle", 1'b0, 3'd3, 6'h00, 1'b0); tick(); check();

    // ---- 3: higher-priority line overtakes while in REQ ----
    irq_in = 6'h10;
    tick(); tick();
    irq_in = 6'h00;
    push("t3_pend4", 1'b0, 3'd3, 6'h10, 1'b0); tick(); check();
    push("t3_req4", 1'b1, 3'd4, 6'h10, 1'b0); tick(); check();
    irq_in = 6'h02;
    push("t3_hold4_a", 1'b1, 3'd4, 6'h10, 1'b0); tick(); check();
    tick();
    irq_in = 6'h00;
    push("t3_pend1", 1'b1, 3'd4, 6'h12, 1'b0); tick(); check();
    push("t3_overtake", 1'b1, 3'd1, 6'h12, 1'b0); tick(); check();
    int_ack = 1'b1;
    push("t3_ack1", 1'b0, 3'd1, 6'h10, 1'b1); tick(); int_ack = 1'b0; check();
    eret = 1'b1;
    push("t3_eret1", 1'b0, 3'd1, 6'h10, 1'b0); tick(); eret = 1'b0; check();
    push("t3_rereq4", 1'b1, 3'd4, 6'h10, 1'b0); tick(); check();
    int_ack = 1'b1;
    push("t3_ack4", 1'b0, 3'd4, 6'h00, 1'b1); tick(); int_ack = 1'b0; check();
    eret = 1'b1;
    push("t3_eret4", 1'b0, 3'd4, 6'h00, 1'b0); tick(); eret = 1'b0; check();

    // ---- 4: masked line pends, unmask requests, IE drop withdraws ----
    irq_mask = 6'h3B;
    irq_in   = 6'h04;
    tick(); tick();
    irq_in = 6'h00;
    push("t4_pend_masked", 1'b0, 3'd4, 6'h04, 1'b0); tick(); check();
    push("t4_no_req_masked", 1'b0, 3'd4, 6'h04, 1'b0); tick(); check();
    irq_mask = 6'h3F;
    push("t4_unmask_req", 1'b1, 3'd2, 6'h04, 1'b0); tick(); check();
    global_ie = 1'b0;
    push("t4_ie_drop", 1'b0, 3'd2, 6'h04, 1'b0); tick(); check();
    global_ie = 1'b1;
    push("t4_ie_restore", 1'b1, 3'd2, 6'h04, 1'b0); tick(); check();
    int_ack = 1'b1;
    push("t4_ack", 1'b0, 3'd2, 6'h00, 1'b1); tick(); int_ack = 1'b0; check();
    eret = 1'b1;
    push("t4_eret", 1'b0, 3'd2, 6'h00, 1'b0); tick(); eret = 1'b0; check();

    // ---- 5: edge on line 5 coincides with its ack; spurious pulses ----
    irq_in = 6'h20;
    tick(); tick();
    irq_in = 6'h00;
    push("t5_pend5", 1'b0, 3'd2, 6'h20, 1'b0); tick(); check();
    push("t5_req5", 1'b1, 3'd5, 6'h20, 1'b0); tick(); check();
    irq_in = 6'h20;
    push("t5_req5_hold", 1'b1, 3'd5, 6'h20, 1'b0); tick(); check();
    tick();
    int_ack = 1'b1;
    push("t5_set_wins", 1'b0, 3'd5, 6'h20, 1'b1); tick(); int_ack = 1'b0; check();
    irq_in  = 6'h00;
    int_ack = 1'b1;
    push("t5_ack_in_service", 1'b0, 3'd5, 6'h20, 1'b1); tick(); int_ack = 1'b0; check();
    global_ie = 1'b0;
    eret      = 1'b1;
    push("t5_eret", 1'b0, 3'd5, 6'h20, 1'b0); tick(); eret = 1'b0; check();
    int_ack = 1'b1;
    push("t5_ack_in_idle", 1'b0, 3'd5, 6'h20, 1'b0); tick(); int_ack = 1'b0; check();
    global_ie = 1'b1;
    push("t5_req_again", 1'b1, 3'd5, 6'h20, 1'b0); tick(); check();
    eret = 1'b1;
    push("t5_eret_in_req", 1'b1, 3'd5, 6'h20, 1'b0); tick(); eret = 1'b0; check();

    // ---- 6: asynchronous reset in the middle of SERVICE ----
    int_ack = 1'b1;
    push("t6_ack", 1'b0, 3'd5, 6'h00, 1'b1); tick(); int_ack = 1'b0; check();
    irq_in = 6'h01;
    tick(); tick();
    push("t6_accumulate", 1'b0, 3'd5, 6'h01, 1'b1); tick(); check();
    #3;
    resetn = 1'b0;
    #1;
    push("t6_async_reset", 1'b0, 3'd0, 6'h00, 1'b0); check();
    tick(); tick();
    resetn = 1'b1;
    tick(); tick();
    push("t6_post_pend", 1'b0, 3'd0, 6'h01, 1'b0); tick(); check();
    push("t6_post_req", 1'b1, 3'd0, 6'h01, 1'b0); tick(); check();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
